// File: rtl/mult64_share_ctrl_if.sv
// Requester-side bus of the shared 64x64 multiplier controller.
// Operands and results are packed per requester, index i in the outer dimension.
interface mult64_share_ctrl_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         sgn;
  logic [NREQ-1:0][63:0]   a;
  logic [NREQ-1:0][63:0]   b;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         res_vld;
  logic [NREQ-1:0][127:0]  res;
  logic [NREQ-1:0]         res_ack;

  modport master (output req, sgn, a, b, res_ack, input gnt, res_vld, res);
  modport slave  (input req, sgn, a, b, res_ack, output gnt, res_vld, res);
endinterface

// File: rtl/mult64_share_ctrl.sv
// Round-robin sharing of one pipelined unsigned 64x64 multiplier among NREQ
// requesters, with sign handling around the core and per-requester result hold.

module mult64_share_ctrl_lane (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         gnt,
  input  logic         hit,
  input  logic         ack,
  input  logic [127:0] prod,
  output logic         idle,
  output logic         res_vld,
  output logic [127:0] res
);
  typedef enum logic [1:0] {IDLE, INFLT, DONE} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res_vld <= 1'b0;
      res     <= '0;
    end else if (ce) begin
      case (state)
        IDLE:  if (gnt) state <= INFLT;
        INFLT: if (hit) begin
          state   <= DONE;
          res_vld <= 1'b1;
          res     <= prod;
        end
        DONE:  if (ack) begin
          state   <= IDLE;
          res_vld <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign idle = (state == IDLE);
endmodule

module mult64_share_ctrl #(
  parameter int NREQ = 4,
  parameter int LAT  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  mult64_share_ctrl_if.slave   bus,
  output logic [63:0]          m_a,
  output logic [63:0]          m_b,
  input  logic [127:0]         m_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic          neg;
  } tag_t;

  // Stage 0 is loaded with m_a/m_b; stages 1..LAT track the multiplier depth.
  tag_t tag_pipe [LAT:0];
  tag_t tail;

  logic [IW-1:0]          p, gidx, cand;
  logic                   any;
  logic [NREQ-1:0]        gnt_c, idle, res_vld_w;
  logic [NREQ-1:0][127:0] res_w;
  logic [63:0]            sel_a, sel_b, abs_a, abs_b;
  logic                   sel_s, neg_c;
  logic [127:0]           prod;

  always_comb begin
    gnt_c = '0;
    gidx  = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(p) + k) % NREQ);
      if (!any && bus.req[cand] && idle[cand]) begin
        any  = 1'b1;
        gidx = cand;
      end
    end
    if (!ce || rst) any = 1'b0;
    if (any) gnt_c[gidx] = 1'b1;
  end

  assign bus.gnt = gnt_c;

  assign sel_a = bus.a[gidx];
  assign sel_b = bus.b[gidx];
  assign sel_s = bus.sgn[gidx];
  // -2^63 negates to itself, which read unsigned is the correct magnitude.
  assign abs_a = (sel_s && sel_a[63]) ? (~sel_a + 64'd1) : sel_a;
  assign abs_b = (sel_s && sel_b[63]) ? (~sel_b + 64'd1) : sel_b;
  assign neg_c = sel_s & (sel_a[63] ^ sel_b[63]);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_a <= '0;
      m_b <= '0;
      p   <= '0;
      for (int k = 0; k <= LAT; k++) tag_pipe[k] <= '0;
    end else if (ce) begin
      if (any) begin
        m_a <= abs_a;
        m_b <= abs_b;
        p   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      tag_pipe[0] <= {any, gidx, neg_c};
      for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tail = tag_pipe[LAT];
  assign prod = tail.neg ? (~m_o + 128'd1) : m_o;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    mult64_share_ctrl_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .gnt     (gnt_c[i]),
      .hit     (tail.vld && (tail.idx == IW'(i))),
      .ack     (bus.res_ack[i]),
      .prod    (prod),
      .idle    (idle[i]),
      .res_vld (res_vld_w[i]),
      .res     (res_w[i])
    );
  end

  assign bus.res_vld = res_vld_w;
  assign bus.res     = res_w;
endmodule

// File: tb/tb_mult64_share_ctrl.sv
// Bench for mult64_share_ctrl: table of single ops plus multi-requester,
// fairness, clock-enable and reset sequences, checked against a scoreboard.
module tb_mult64_share_ctrl;
  localparam int NREQ = 4;
  localparam int LAT  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic [63:0]  m_a, m_b;
  logic [127:0] m_o;

  mult64_share_ctrl_if #(.NREQ(NREQ)) bus ();

  mult64_share_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk (clk), .rst (rst), .ce (ce), .bus (bus),
    .m_a (m_a), .m_b (m_b), .m_o (m_o)
  );

  always #5 clk = ~clk;

  // Unsigned multiplier of depth LAT sharing ce.
  logic [127:0] mpipe [LAT];
  always @(posedge clk) if (ce) begin
    mpipe[0] <= {64'b0, m_a} * {64'b0, m_b};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign m_o = mpipe[LAT-1];

  int total = 0, bad = 0, cyc = 0, ce_cnt = 0;

  typedef struct { int idx; logic [127:0] val; int ce_at; } sb_t;
  sb_t sbq [$];
  int glog [$], gcyc [$], rlog [$], rcyc [$];
  logic [NREQ-1:0] busy = '0, prev_vld = '0;

  typedef struct { int idx; logic s; logic [63:0] a; logic [63:0] b; logic [127:0] exp; } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] model_mul(input logic s, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sx, sy;
    if (s) begin
      sx = {{64{x[63]}}, x};
      sy = {{64{y[63]}}, y};
      return sx * sy;
    end
    return {64'b0, x} * {64'b0, y};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (ce && !rst) ce_cnt++;
  end

  // Grants are sampled the cycle before the grant edge, so a result
  // LAT+1 edges after that edge is seen LAT+2 sampled cycles later.
  initial forever begin
    @(negedge clk);
    if (rst || !ce) begin
      chk("gnt_blocked", bus.gnt, '0);
      if (rst) begin sbq.delete(); busy = '0; end
    end else begin
      if (bus.gnt != '0) begin
        chk("gnt_onehot", $onehot(bus.gnt), 1);
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) begin
          chk("gnt_to_busy", busy[i], 0);
          busy[i] = 1'b1;
          sbq.push_back('{i, model_mul(bus.sgn[i], bus.a[i], bus.b[i]), ce_cnt});
          glog.push_back(i);
          gcyc.push_back(cyc);
        end
      end
      for (int i = 0; i < NREQ; i++) if (bus.res_vld[i] && bus.res_ack[i]) busy[i] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) if (bus.res_vld[i] && !prev_vld[i]) begin
      if (sbq.size() == 0) chk("spurious_vld", 1, 0);
      else begin
        sb_t e;
        e = sbq.pop_front();
        chk("retire_idx", i, e.idx);
        chk("retire_val", bus.res[i], e.val);
        chk("retire_lat", ce_cnt - e.ce_at, LAT + 2);
      end
      rlog.push_back(i);
      rcyc.push_back(cyc);
    end
    prev_vld = bus.res_vld;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_gnt(input int idx, input string name, output int n, output int c);
    n = 0;
    @(negedge clk);
    while (!bus.gnt[idx] && n < 40) begin n++; @(negedge clk); end
    chk(name, bus.gnt[idx], 1);
    c = cyc;
  endtask

  task automatic wait_vld(input int idx, input string name, output int c);
    int n = 0;
    @(negedge clk);
    while (!bus.res_vld[idx] && n < 40) begin n++; @(negedge clk); end
    chk(name, bus.res_vld[idx], 1);
    c = cyc;
  endtask

  task automatic run_op(input int idx, input logic s, input logic [63:0] x,
                        input logic [63:0] y, input logic [127:0] exp);
    int n, gc, rc;
    @(posedge clk); #1;
    bus.sgn[idx] = s; bus.a[idx] = x; bus.b[idx] = y; bus.req[idx] = 1'b1;
    wait_gnt(idx, "op_gnt", n, gc);
    chk("op_gnt_first_cycle", n, 0);
    @(posedge clk); #1 bus.req[idx] = 1'b0;
    wait_vld(idx, "op_vld", rc);
    chk("op_latency", rc - gc, LAT + 2);
    chk("op_res", bus.res[idx], exp);
    repeat (2) begin
      @(negedge clk);
      chk("op_hold_vld", bus.res_vld[idx], 1);
      chk("op_hold_res", bus.res[idx], exp);
    end
    @(posedge clk); #1 bus.res_ack[idx] = 1'b1;
    @(posedge clk); #1 bus.res_ack[idx] = 1'b0;
    @(negedge clk);
    chk("op_ack_clr", bus.res_vld[idx], 0);
    chk("op_res_keep", bus.res[idx], exp);
  endtask

  task automatic issue_drop(input int ncyc);
    logic [NREQ-1:0] g;
    repeat (ncyc) begin
      @(negedge clk); g = bus.gnt;
      @(posedge clk); #1 bus.req = bus.req & ~g;
    end
  endtask

  initial begin
    int gc, rc, n;
    vt[0] = '{0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE};
    vt[1] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
    vt[2] = '{2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0000_8000_0000_0000_0000};
    vt[3] = '{3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 128'h7FFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
    vt[4] = '{0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vt[5] = '{1, 1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB};
    vt[6] = '{2, 1'b0, 64'd0, 64'hDEAD_BEEF_0123_4567, 128'd0};
    vt[7] = '{3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};

    bus.sgn = '0; bus.a = '0; bus.b = '0; bus.res_ack = '0;
    bus.req = '1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_res_vld", bus.res_vld, '0);
    for (int i = 0; i < NREQ; i++) chk("rst_res", bus.res[i], '0);
    chk("rst_m_a", m_a, '0);
    chk("rst_m_b", m_b, '0);
    @(posedge clk); #1 rst = 1'b0; bus.req = '0;

    for (int t = 0; t < 8; t++) run_op(vt[t].idx, vt[t].s, vt[t].a, vt[t].b, vt[t].exp);

    // All four requesting out of reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.sgn[i] = i[0];
      bus.a[i] = {$urandom, $urandom};
      bus.b[i] = {$urandom, $urandom};
    end
    glog.delete(); gcyc.delete(); rlog.delete(); rcyc.delete();
    bus.req = '1;
    issue_drop(4);
    n = 0;
    while (rlog.size() < 4 && n < 40) begin n++; @(negedge clk); end
    chk("all4_ngnt", glog.size(), 4);
    chk("all4_nret", rlog.size(), 4);
    if (glog.size() == 4 && rlog.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("all4_gnt_order", glog[k], k);
        chk("all4_gnt_cyc", gcyc[k] - gcyc[0], k);
        chk("all4_ret_order", rlog[k], k);
        chk("all4_ret_cyc", rcyc[k] - rcyc[0], k);
      end
    @(posedge clk); #1 bus.res_ack = '1;
    @(posedge clk); #1 bus.res_ack = '0;

    // Requesters 1 and 3 hammer, acking in their first DONE cycle.
    glog.delete();
    bus.a[1] = 64'h0123_4567_89AB_CDEF; bus.b[1] = 64'hFFFF_FFFF_FFFF_FFF0; bus.sgn[1] = 1'b1;
    bus.a[3] = 64'hFEDC_BA98_7654_3210; bus.b[3] = 64'h0000_0000_0001_0001; bus.sgn[3] = 1'b0;
    bus.req = 4'b1010;
    repeat (60) begin @(posedge clk); #1 bus.res_ack = bus.res_vld & 4'b1010; end
    bus.req = '0;
    repeat (LAT + 6) begin @(posedge clk); #1 bus.res_ack = bus.res_vld & 4'b1010; end
    bus.res_ack = '0;
    chk("rr_enough_gnts", glog.size() >= 6, 1);
    for (int k = 0; k < glog.size(); k++) chk("rr_alternate", glog[k], (k % 2) ? 3 : 1);
    chk("rr_idle", bus.res_vld, '0);

    // ce low for 5 cycles with requester 0 in flight and requester 1 waiting.
    @(posedge clk); #1;
    bus.sgn[0] = 1'b0; bus.a[0] = 64'd1000003; bus.b[0] = 64'd999983; bus.req[0] = 1'b1;
    wait_gnt(0, "ce_gnt0", n, gc);
    @(posedge clk); #1 bus.req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 ce = 1'b0;
    bus.sgn[1] = 1'b1; bus.a[1] = 64'hFFFF_FFFF_FFFF_FFFE; bus.b[1] = 64'd3; bus.req[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 ce = 1'b1;
    wait_gnt(1, "ce_gnt1_after", n, rc);
    chk("ce_gnt1_first_cycle", n, 0);
    @(posedge clk); #1 bus.req[1] = 1'b0;
    wait_vld(0, "ce_vld0", rc);
    chk("ce_latency", rc - gc, LAT + 2 + 5);
    chk("ce_res0", bus.res[0], 128'd999985999949);
    @(posedge clk); #1 ce = 1'b0; bus.res_ack[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ce_ack_ignored", bus.res_vld[0], 1);
    @(posedge clk); #1 ce = 1'b1;
    @(posedge clk); #1 bus.res_ack[0] = 1'b0;
    @(negedge clk);
    chk("ce_ack_taken", bus.res_vld[0], 0);
    wait_vld(1, "ce_vld1", rc);
    chk("ce_res1", bus.res[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    @(posedge clk); #1 bus.res_ack[1] = 1'b1;
    @(posedge clk); #1 bus.res_ack[1] = 1'b0;

    // Reset with one DONE and three in flight.
    @(posedge clk); #1;
    bus.sgn[3] = 1'b0; bus.a[3] = 64'd77; bus.b[3] = 64'd91; bus.req[3] = 1'b1;
    wait_gnt(3, "rst_seq_gnt3", n, gc);
    @(posedge clk); #1 bus.req[3] = 1'b0;
    wait_vld(3, "rst_seq_vld3", rc);
    chk("rst_seq_res3", bus.res[3], 128'd7007);
    @(posedge clk); #1 bus.req = 4'b0111;
    issue_drop(3);
    chk("rst_seq_busy", busy, 4'b1111);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", bus.res_vld, '0);
    for (int i = 0; i < NREQ; i++) chk("rst_mid_res", bus.res[i], '0);
    chk("rst_mid_m_a", m_a, '0);
    repeat (LAT + 4) begin @(negedge clk); chk("rst_no_late_vld", bus.res_vld, '0); end
    run_op(2, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd256,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
